// File: rtl/trace_cmd_issuer.sv
// Cache command transmitter: trace records are queued in a FIFO, decoded, and
// issued to the instruction cache, the data cache, or both, holding while busy.
module trace_cmd_issuer #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_n,
  input  logic [N-1:0]     in_addr,
  output logic             ic_valid,
  output logic [3:0]       ic_n,
  output logic [N-1:0]     ic_addr,
  input  logic             ic_busy,
  output logic             dc_valid,
  output logic [3:0]       dc_n,
  output logic [N-1:0]     dc_addr,
  input  logic             dc_busy,
  output logic [CNT_W-1:0] ic_count,
  output logic [CNT_W-1:0] dc_count,
  output logic [CNT_W-1:0] bad_count,
  output logic             idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BOTH} state_t;

  logic [3:0]   n_mem_q [DEPTH];
  logic [N-1:0] a_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          empty, full, push, pop;
  logic [3:0]    head_n;
  logic [N-1:0]  head_a;
  logic          to_ic, to_dc;

  state_t        state_q, state_d;
  logic          ic_valid_q, ic_valid_d, dc_valid_q, dc_valid_d;
  logic [3:0]    ic_n_q, ic_n_d, dc_n_q, dc_n_d;
  logic [N-1:0]  ic_addr_q, ic_addr_d, dc_addr_q, dc_addr_d;
  logic [CNT_W-1:0] ic_cnt_q, dc_cnt_q, bad_cnt_q;
  logic          ic_acc, dc_acc, done, bad_inc;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head_n   = n_mem_q[rd_ptr_q[AW-1:0]];
  assign head_a   = a_mem_q[rd_ptr_q[AW-1:0]];

  assign to_ic = (head_n == 4'd2) || (head_n == 4'd8) || (head_n == 4'd9);
  assign to_dc = (head_n == 4'd0) || (head_n == 4'd1) || (head_n == 4'd3) ||
                 (head_n == 4'd4) || (head_n == 4'd8) || (head_n == 4'd9);

  assign ic_acc = ic_valid_q && !ic_busy;
  assign dc_acc = dc_valid_q && !dc_busy;
  // Current command fully retired (or none held): next head may load this cycle.
  assign done   = (state_q == IDLE) ||
                  (!(ic_valid_q && ic_busy) && !(dc_valid_q && dc_busy));

  always_comb begin
    state_d    = state_q;
    ic_valid_d = ic_valid_q && ic_busy;
    dc_valid_d = dc_valid_q && dc_busy;
    ic_n_d     = ic_n_q;
    ic_addr_d  = ic_addr_q;
    dc_n_d     = dc_n_q;
    dc_addr_d  = dc_addr_q;
    pop        = 1'b0;
    bad_inc    = 1'b0;
    if (done) begin
      state_d = IDLE;
      if (!empty) begin
        pop = 1'b1;
        if (to_ic) begin
          ic_valid_d = 1'b1;
          ic_n_d     = head_n;
          ic_addr_d  = head_a;
        end
        if (to_dc) begin
          dc_valid_d = 1'b1;
          dc_n_d     = head_n;
          dc_addr_d  = head_a;
        end
        if (to_ic && to_dc)      state_d = BOTH;
        else if (to_ic || to_dc) state_d = ISSUE;
        else                     bad_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      n_mem_q[wr_ptr_q[AW-1:0]] <= in_n;
      a_mem_q[wr_ptr_q[AW-1:0]] <= in_addr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= IDLE;
      ic_valid_q <= 1'b0;
      dc_valid_q <= 1'b0;
      ic_n_q     <= '0;
      dc_n_q     <= '0;
      ic_addr_q  <= '0;
      dc_addr_q  <= '0;
      ic_cnt_q   <= '0;
      dc_cnt_q   <= '0;
      bad_cnt_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      state_q    <= state_d;
      ic_valid_q <= ic_valid_d;
      dc_valid_q <= dc_valid_d;
      ic_n_q     <= ic_n_d;
      dc_n_q     <= dc_n_d;
      ic_addr_q  <= ic_addr_d;
      dc_addr_q  <= dc_addr_d;
      // Counters stick at all-ones.
      if (ic_acc && ic_cnt_q != {CNT_W{1'b1}})   ic_cnt_q  <= ic_cnt_q + CNT_W'(1);
      if (dc_acc && dc_cnt_q != {CNT_W{1'b1}})   dc_cnt_q  <= dc_cnt_q + CNT_W'(1);
      if (bad_inc && bad_cnt_q != {CNT_W{1'b1}}) bad_cnt_q <= bad_cnt_q + CNT_W'(1);
    end
  end

  assign ic_valid  = ic_valid_q;
  assign ic_n      = ic_n_q;
  assign ic_addr   = ic_addr_q;
  assign dc_valid  = dc_valid_q;
  assign dc_n      = dc_n_q;
  assign dc_addr   = dc_addr_q;
  assign ic_count  = ic_cnt_q;
  assign dc_count  = dc_cnt_q;
  assign bad_count = bad_cnt_q;
  assign idle      = empty && (state_q == IDLE);
endmodule

// File: tb/tb_trace_cmd_issuer.sv
// Bench for trace_cmd_issuer: directed scenarios with literal expectations plus
// randomized traffic scored against an in-order transaction model.
module tb_trace_cmd_issuer;
  localparam int N     = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clock = 0, reset = 0;
  logic             in_valid = 0, ic_busy = 0, dc_busy = 0;
  logic [3:0]       in_n = 0;
  logic [N-1:0]     in_addr = 0;
  logic             in_ready, ic_valid, dc_valid, idle;
  logic [3:0]       ic_n, dc_n;
  logic [N-1:0]     ic_addr, dc_addr;
  logic [CNT_W-1:0] ic_count, dc_count, bad_count;

  int tests = 0, fails = 0;

  trace_cmd_issuer #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_n(in_n), .in_addr(in_addr),
    .ic_valid(ic_valid), .ic_n(ic_n), .ic_addr(ic_addr), .ic_busy(ic_busy),
    .dc_valid(dc_valid), .dc_n(dc_n), .dc_addr(dc_addr), .dc_busy(dc_busy),
    .ic_count(ic_count), .dc_count(dc_count), .bad_count(bad_count), .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit wants_ic(input logic [3:0] n);
    return n == 2 || n == 8 || n == 9;
  endfunction
  function automatic bit wants_dc(input logic [3:0] n);
    return n inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd8, 4'd9};
  endfunction
  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // Model: legal records in trace order; only the oldest may be on the buses.
  typedef struct {
    logic [3:0]   n;
    logic [N-1:0] a;
    bit           need_ic;
    bit           need_dc;
  } rec_t;
  rec_t mq[$];
  int   m_ic = 0, m_dc = 0, m_bad = 0;

  initial begin
    bit           ic_a, dc_a, pu;
    logic [3:0]   pn;
    logic [N-1:0] pa;
    rec_t         h;
    forever begin
      @(negedge clock); #1;
      if (!reset) begin
        mq.delete(); m_ic = 0; m_dc = 0; m_bad = 0;
      end else begin
        chk("mon_ic_count", ic_count, m_ic);
        chk("mon_dc_count", dc_count, m_dc);
        if (ic_valid) begin
          if (mq.size() == 0 || !mq[0].need_ic) chk("mon_ic_valid_unexpected", ic_valid, 0);
          else begin
            chk("mon_ic_n", ic_n, mq[0].n);
            chk("mon_ic_addr", ic_addr, mq[0].a);
          end
        end
        if (dc_valid) begin
          if (mq.size() == 0 || !mq[0].need_dc) chk("mon_dc_valid_unexpected", dc_valid, 0);
          else begin
            chk("mon_dc_n", dc_n, mq[0].n);
            chk("mon_dc_addr", dc_addr, mq[0].a);
          end
        end
        ic_a = ic_valid && !ic_busy;
        dc_a = dc_valid && !dc_busy;
        pu   = in_valid && in_ready;
        pn   = in_n;
        pa   = in_addr;
        @(posedge clock);
        if (!reset) begin
          mq.delete(); m_ic = 0; m_dc = 0; m_bad = 0;
        end else begin
          if (mq.size() > 0) begin
            h = mq[0];
            if (ic_a) begin h.need_ic = 0; m_ic = sat(m_ic); end
            if (dc_a) begin h.need_dc = 0; m_dc = sat(m_dc); end
            if (!h.need_ic && !h.need_dc) void'(mq.pop_front());
            else mq[0] = h;
          end
          if (pu) begin
            if (wants_ic(pn) || wants_dc(pn)) begin
              h.n = pn; h.a = pa; h.need_ic = wants_ic(pn); h.need_dc = wants_dc(pn);
              mq.push_back(h);
            end else m_bad = sat(m_bad);
          end
        end
      end
    end
  end

  initial begin
    int acc;
    logic [3:0] ns3 [3] = '{4'd0, 4'd1, 4'd3};
    bit         ev [6]  = '{0, 0, 1, 1, 1, 0};
    logic [3:0] lg [7]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};

    repeat (2) @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_ic_valid", ic_valid, 0);
    chk("rst_dc_valid", dc_valid, 0);
    chk("rst_ic_n", ic_n, 0);
    chk("rst_dc_addr", dc_addr, 0);
    chk("rst_counts", {ic_count, dc_count, bad_count}, 0);
    reset = 1;

    // Single IC command: visible two cycles after the push cycle.
    @(negedge clock); in_valid = 1; in_n = 2; in_addr = 32'h0040_1000;
    @(negedge clock); chk("single_early_ic_valid", ic_valid, 0); in_valid = 0;
    @(negedge clock);
    chk("single_ic_valid", ic_valid, 1);
    chk("single_ic_n", ic_n, 2);
    chk("single_ic_addr", ic_addr, 32'h0040_1000);
    chk("single_dc_valid", dc_valid, 0);
    @(negedge clock);
    chk("single_ic_drop", ic_valid, 0);
    chk("single_ic_count", ic_count, 1);
    chk("single_idle", idle, 1);

    // Back-to-back DC commands issue on consecutive cycles.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk($sformatf("b2b_dc_valid_%0d", i), dc_valid, ev[i]);
      if (ev[i]) chk($sformatf("b2b_dc_addr_%0d", i), dc_addr, 32'h10 * (i - 1));
      in_valid = (i < 3);
      if (i < 3) begin in_n = ns3[i]; in_addr = 32'h10 * (i + 1); end
    end
    chk("b2b_dc_count", dc_count, 3);

    // Clear to both caches with the DC side busy; next IC record must wait.
    @(negedge clock); in_valid = 1; in_n = 8; in_addr = 32'hC1EA_0000; dc_busy = 1;
    @(negedge clock); in_n = 2; in_addr = 32'h0000_2000;
    @(negedge clock); in_valid = 0;
    chk("both_ic_valid", ic_valid, 1);
    chk("both_dc_valid", dc_valid, 1);
    chk("both_dc_n", dc_n, 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("both_hold_ic_valid_%0d", i), ic_valid, 0);
      chk($sformatf("both_hold_dc_valid_%0d", i), dc_valid, 1);
    end
    chk("both_ic_count", ic_count, 2);
    dc_busy = 0;
    @(negedge clock);
    chk("after_both_ic_valid", ic_valid, 1);
    chk("after_both_ic_addr", ic_addr, 32'h0000_2000);
    chk("after_both_dc_valid", dc_valid, 0);
    chk("after_both_dc_count", dc_count, 4);
    @(negedge clock);
    chk("after_both_ic_count", ic_count, 3);

    // Illegal code is discarded without touching either cache.
    @(negedge clock); in_valid = 1; in_n = 5; in_addr = 32'h55;
    @(negedge clock); in_n = 2; in_addr = 32'h22;
    @(negedge clock); in_valid = 0;
    chk("bad_no_ic", ic_valid, 0);
    chk("bad_count_1", bad_count, 1);
    @(negedge clock);
    chk("bad_then_ic_valid", ic_valid, 1);
    chk("bad_then_ic_addr", ic_addr, 32'h22);
    @(negedge clock);
    chk("bad_ic_count", ic_count, 4);
    chk("bad_dc_valid", dc_valid, 0);

    // Backpressure: DEPTH in FIFO plus one held in the output register.
    dc_busy = 1; acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      in_valid = 1; in_n = 3; in_addr = 32'h300 + acc;
      if (in_ready) acc++;
    end
    @(negedge clock);
    chk("fill_in_ready", in_ready, 0);
    in_valid = 0;
    chk("fill_accepted", acc, DEPTH + 1);
    dc_busy = 0;
    for (int k = 0; k < 50 && !idle; k++) @(negedge clock);
    chk("fill_drain_idle", idle, 1);
    chk("fill_dc_count", dc_count, 4 + DEPTH + 1);

    // Asynchronous reset mid-issue with the FIFO half full.
    dc_busy = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); in_valid = 1; in_n = 4; in_addr = 32'h400 + i;
    end
    @(negedge clock); in_valid = 0;
    @(negedge clock);
    chk("pre_rst_dc_valid", dc_valid, 1);
    #3 reset = 0;
    #1;
    chk("arst_valids", {ic_valid, dc_valid}, 0);
    chk("arst_counts", {ic_count, dc_count, bad_count}, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_idle", idle, 1);
    chk("arst_dc_n_addr", {dc_n, dc_addr}, 0);
    @(negedge clock); reset = 1; dc_busy = 0;

    // Random traffic with phases of light and heavy backpressure.
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      in_valid = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) < 8) in_n = lg[$urandom_range(0, 6)];
      else in_n = 4'($urandom_range(10, 15));
      in_addr = $urandom;
      if (((c / 200) % 2) == 1) begin
        ic_busy = ($urandom_range(0, 3) != 0);
        dc_busy = ($urandom_range(0, 3) != 0);
      end else begin
        ic_busy = ($urandom_range(0, 3) == 0);
        dc_busy = ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clock); in_valid = 0; ic_busy = 0; dc_busy = 0;
    for (int k = 0; k < 200 && !idle; k++) @(negedge clock);
    chk("rand_drain_idle", idle, 1);
    @(negedge clock); @(negedge clock);
    chk("rand_outstanding", mq.size(), 0);
    chk("rand_ic_count", ic_count, m_ic);
    chk("rand_dc_count", dc_count, m_dc);
    chk("rand_bad_count", bad_count, m_bad);
    chk("rand_dc_saturated", dc_count, CMAX);
    chk("rand_in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/trace_cmd_issuer.md
Name: trace_cmd_issuer

Overview:
- Hardware-side transmitter of the cache command interface (4-bit command code n plus N-bit address) that the instruction and data caches consume.
- A loader pushes trace records through a valid/ready handshake into an internal FIFO.
- The issuer decodes each record, routes it to the instruction cache, the data cache, or both, and holds it while the target reports busy.
- Enables cycle-accurate trace replay without file I/O.

Parameters:
- N, 32: address width.
- DEPTH, 8: FIFO entries; power of 2, at least 2.
- CNT_W, 16: width of the statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  loader record valid.
- in_ready  out  1  FIFO can accept a record.
- in_n  in  4  command code.
- in_addr  in  N  address.
- ic_valid  out  1  instruction cache command valid.
- ic_n  out  4  command to the instruction cache.
- ic_addr  out  N  address to the instruction cache.
- ic_busy  in  1  instruction cache cannot accept.
- dc_valid  out  1  data cache command valid.
- dc_n  out  4  command to the data cache.
- dc_addr  out  N  address to the data cache.
- dc_busy  in  1  data cache cannot accept.
- ic_count  out  CNT_W  commands accepted by the instruction cache.
- dc_count  out  CNT_W  commands accepted by the data cache.
- bad_count  out  CNT_W  illegal codes discarded.
- idle  out  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty; FSM in IDLE; all valids 0; n/addr outputs 0; counters 0; idle=1; in_ready=1.
- FIFO:
  - Push when in_valid && in_ready; in_ready = !full.
  - Simultaneous push and pop when full is not allowed: in_ready stays registered-low while full.
  - Push and pop in the same cycle when not full or empty: occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- Routing decode of the FIFO head:
  - n=2 -> IC only.
  - n=0,1,3,4 -> DC only.
  - n=8 (clear) or 9 (print) -> both caches.
  - Any other n -> discarded: popped in 1 cycle, bad_count++, nothing driven.
- FSM states: IDLE, ISSUE, BOTH.
  - IDLE: if FIFO not empty, load the head into the output registers and pop it.
    - Single target -> ISSUE.
    - Both targets -> BOTH.
    - Illegal code -> stay in IDLE.
    - Latency: record pushed at cycle t appears on ic_/dc_valid at t+2 when the FIFO was empty.
  - ISSUE: target valid=1; n/addr stable.
    - Accept when valid && !busy on a rising edge; increment the matching count.
    - After accept, load the next head back-to-back if present (no bubble), else go to IDLE with valids=0.
  - BOTH: ic_valid and dc_valid both asserted.
    - Each side drops its valid independently once accepted.
    - Leave BOTH only when both sides have accepted.
    - Both counts increment on their own accept cycles.
    - Ordering: no later record issues until both sides accept, which preserves trace ordering around clear/print.
- Busy held indefinitely: outputs hold; the FIFO fills; in_ready drops.
- Counters saturate at all-ones and do not wrap.
- idle = (FIFO empty) && (state==IDLE).
- Reset asserted mid-operation: all in-flight and queued records are lost; outputs return to reset values immediately.

Test Plan:
- Reset then single push (n=2, addr=0x0040_1000) -> ic_valid=1 at t+2 with ic_n=2 and that address; dc_valid stays 0; ic_count=1; idle returns to 1.
- Back-to-back pushes (n=0, 0x10), (n=1, 0x20), (n=3, 0x30), no busy -> dc_valid high for 3 consecutive cycles with addresses in order; dc_count=3.
- Push n=8 with ic_busy=0 and dc_busy=1 for 4 cycles -> ic accepts at the first cycle and ic_valid drops; dc_valid held 4 more cycles; the following record (n=2) issues only after dc accepts.
- Push n=5 then n=2 -> bad_count=1; only the n=2 command appears on the instruction cache outputs.
- dc_busy=1 held while pushing DEPTH+2 data records -> in_ready=0 after DEPTH+1 accepted pushes (DEPTH in FIFO plus 1 in the output register); release busy -> all records drain in order; final dc_count=DEPTH+1.
- Assert reset low mid-ISSUE with FIFO half full -> valids=0, counters=0, in_ready=1 and idle=1 without waiting for a clock edge.
